// File: rtl/spike_out_reader_if.sv
// rtl/spike_out_reader_if.sv - Wishbone initiator/slave signal bundle for the spike-out reader
interface spike_out_reader_if;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_dat_i, wbm_ack_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_dat_i, wbm_ack_i
   );
endinterface

// File: rtl/spike_out_reader.sv
// rtl/spike_out_reader.sv - Wishbone initiator reading the neuron core spike-out bank into spikes_o
// Words are gathered in a shadow buffer and committed to spikes_o only on a fully successful transfer.
module spike_out_reader #(
   parameter logic [31:0] SPIKE_OUT_BASE = 32'h3000_8000,
   parameter int          NUM_WORDS      = 8,
   parameter int          TIMEOUT        = 16
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic [32*NUM_WORDS-1:0]  spikes_o,
   spike_out_reader_if.master       wbm
);
   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DONE} state_t;

   state_t                      r_state, w_state_nxt;
   logic [IDX_W-1:0]            r_idx, w_idx_nxt;
   logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
   logic [NUM_WORDS-1:0][31:0]  r_shadow, w_shadow_nxt;
   logic [NUM_WORDS-1:0][31:0]  r_spikes, w_spikes_nxt;
   logic [31:0]                 r_adr, w_adr_nxt;
   logic                        r_cyc, r_busy, r_done, r_err, w_err_nxt;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_cnt_nxt    = r_cnt;
      w_shadow_nxt = r_shadow;
      w_spikes_nxt = r_spikes;
      w_err_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_nxt  = S_REQ;
               w_idx_nxt    = '0;
               w_cnt_nxt    = '0;
               w_shadow_nxt = '0;
            end
         end
         S_REQ: begin
            if (wbm.wbm_ack_i) begin
               w_shadow_nxt[r_idx] = wbm.wbm_dat_i;
               if (r_idx == LAST_IDX) begin
                  w_state_nxt  = S_DONE;
                  w_spikes_nxt = w_shadow_nxt;
               end else begin
                  w_state_nxt = S_GAP;
                  w_idx_nxt   = r_idx + IDX_W'(1);
               end
            end else if (r_cnt == LAST_CNT) begin
               w_state_nxt = S_DONE;
               w_err_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_GAP: begin
            // One idle cycle so a registered-ack slave never sees back-to-back strobes
            w_state_nxt = S_REQ;
            w_cnt_nxt   = '0;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_adr_nxt = SPIKE_OUT_BASE + {{(30-IDX_W){1'b0}}, w_idx_nxt, 2'b00};
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_idx    <= '0;
         r_cnt    <= '0;
         r_shadow <= '0;
         r_spikes <= '0;
         r_adr    <= SPIKE_OUT_BASE;
         r_cyc    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_idx    <= w_idx_nxt;
         r_cnt    <= w_cnt_nxt;
         r_shadow <= w_shadow_nxt;
         r_spikes <= w_spikes_nxt;
         r_adr    <= w_adr_nxt;
         r_cyc    <= (w_state_nxt == S_REQ);
         r_busy   <= (w_state_nxt == S_REQ) || (w_state_nxt == S_GAP);
         r_done   <= (w_state_nxt == S_DONE);
         r_err    <= w_err_nxt;
      end
   end

   assign busy_o        = r_busy;
   assign done_o        = r_done;
   assign err_o         = r_err;
   assign spikes_o      = r_spikes;
   assign wbm.wbm_cyc_o = r_cyc;
   assign wbm.wbm_stb_o = r_cyc;
   assign wbm.wbm_we_o  = 1'b0;
   assign wbm.wbm_sel_o = 4'hF;
   assign wbm.wbm_adr_o = r_adr;
   assign wbm.wbm_dat_o = 32'h0;
endmodule
